packet_disassembler: RTL and testbench

- Sink-side counterpart of the HDMI data-island packet assembler.
- Consumes the 9-bit per-pixel TERC4-decoded packet word stream during data island periods and rebuilds each 32-pixel packet: 24-bit header plus four 56-bit subpackets.
- Checks all five BCH parity blocks and presents each completed packet with a one-cycle valid strobe.
- Sits behind the TMDS/TERC4 decoder in the loopback/lag-measurement receive path; downstream InfoFrame decoders consume its outputs.

---
 rtl/packet_disassembler.sv | 136 +++++++++++++
 tb/tb_packet_disassembler.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_disassembler.sv
// Receive-side HDMI data-island packet rebuilder: gathers 32 TERC4-decoded words into header
// and subpackets, verifies the BCH parity, and flags completed and truncated packets.
module packet_disassembler #(
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       data_island_period,
    input  logic [8:0]                 packet_data,
    output logic [23:0]                header,
    output logic [223:0]               sub,
    output logic                       header_ecc_ok,
    output logic [3:0]                 sub_ecc_ok,
    output logic                       packet_valid,
    output logic                       packet_abort,
    output logic [ERR_COUNT_WIDTH-1:0] ecc_error_count,
    output logic [ERR_COUNT_WIDTH-1:0] abort_count
);

    localparam logic [7:0] BCH_POLY = 8'b1000_0011;

    function automatic logic [7:0] lfsr_step(input logic [7:0] ecc, input logic b);
        return {1'b0, ecc[7:1]} ^ ({8{ecc[0] ^ b}} & BCH_POLY);
    endfunction

    function automatic logic [ERR_COUNT_WIDTH-1:0] sat_inc(input logic [ERR_COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [1:0]        rst_sync;
    logic              rst_n_int;
    logic [4:0]        k;
    logic [23:0]       hdr_work;
    logic [7:0]        hdr_ecc;
    logic [7:0]        hdr_par;
    logic [3:0][55:0]  sub_work;
    logic [3:0][7:0]   sub_ecc;
    logic [3:0][7:0]   sub_par;

    logic [7:0]        hdr_ecc_next;
    logic [3:0][7:0]   sub_ecc_mid;
    logic [3:0][7:0]   sub_ecc_next;
    logic              hdr_ok_now;
    logic [3:0]        sub_ok_now;
    logic              last_word;
    logic              abort_now;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    // The LFSRs restart from zero on the first pixel of every packet.
    always_comb begin
        hdr_ecc_next = lfsr_step((k == 5'd0) ? 8'h00 : hdr_ecc, packet_data[0]);
        sub_ecc_mid  = '0;
        sub_ecc_next = '0;
        sub_ok_now   = '0;
        for (int n = 0; n < 4; n++) begin
            sub_ecc_mid[n]  = lfsr_step((k == 5'd0) ? 8'h00 : sub_ecc[n], packet_data[1+n]);
            sub_ecc_next[n] = lfsr_step(sub_ecc_mid[n], packet_data[5+n]);
            sub_ok_now[n]   = (sub_ecc[n] == {packet_data[5+n], packet_data[1+n], sub_par[n][5:0]});
        end
        hdr_ok_now = (hdr_ecc == {packet_data[0], hdr_par[6:0]});
        last_word  = data_island_period && (k == 5'd31);
        abort_now  = !data_island_period && (k != 5'd0);
    end

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            k               <= '0;
            hdr_work        <= '0;
            hdr_ecc         <= '0;
            hdr_par         <= '0;
            sub_work        <= '0;
            sub_ecc         <= '0;
            sub_par         <= '0;
            header          <= '0;
            sub             <= '0;
            header_ecc_ok   <= 1'b0;
            sub_ecc_ok      <= '0;
            packet_valid    <= 1'b0;
            packet_abort    <= 1'b0;
            ecc_error_count <= '0;
            abort_count     <= '0;
        end else begin
            packet_valid <= last_word;
            packet_abort <= abort_now;

            if (!data_island_period) begin
                k <= '0;
            end else begin
                k <= k + 5'd1;
                if (k < 5'd24) begin
                    hdr_work[k] <= packet_data[0];
                    hdr_ecc     <= hdr_ecc_next;
                end else begin
                    hdr_par[k[2:0]] <= packet_data[0];
                end
                // Pixels 28..31 carry parity pairs; k[1:0] is the pair index there.
                for (int n = 0; n < 4; n++) begin
                    if (k < 5'd28) begin
                        sub_work[n][{k, 1'b0}] <= packet_data[1+n];
                        sub_work[n][{k, 1'b1}] <= packet_data[5+n];
                        sub_ecc[n]             <= sub_ecc_next[n];
                    end else begin
                        sub_par[n][{k[1:0], 1'b0}] <= packet_data[1+n];
                        sub_par[n][{k[1:0], 1'b1}] <= packet_data[5+n];
                    end
                end
            end

            // The final parity bits arrive with the last word, so compare against the live input.
            if (last_word) begin
                header        <= hdr_work;
                sub           <= sub_work;
                header_ecc_ok <= hdr_ok_now;
                sub_ecc_ok    <= sub_ok_now;
                if (!hdr_ok_now || !(&sub_ok_now)) begin
                    ecc_error_count <= sat_inc(ecc_error_count);
                end
            end

            if (abort_now) begin
                abort_count <= sat_inc(abort_count);
            end
        end
    end

endmodule

// File: tb/tb_packet_disassembler.sv
// Randomized bench for packet_disassembler with a packet-level reference model.
module tb_packet_disassembler;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         data_island_period = 1'b0;
    logic [8:0]   packet_data = '0;

    logic [23:0]  header;
    logic [223:0] sub;
    logic         header_ecc_ok;
    logic [3:0]   sub_ecc_ok;
    logic         packet_valid;
    logic         packet_abort;
    logic [15:0]  ecc_error_count;
    logic [15:0]  abort_count;

    logic [23:0]  s_header;
    logic [223:0] s_sub;
    logic         s_header_ecc_ok;
    logic [3:0]   s_sub_ecc_ok;
    logic         s_packet_valid;
    logic         s_packet_abort;
    logic [2:0]   s_ecc_error_count;
    logic [2:0]   s_abort_count;

    packet_disassembler #(.ERR_COUNT_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .data_island_period(data_island_period),
        .packet_data(packet_data), .header(header), .sub(sub),
        .header_ecc_ok(header_ecc_ok), .sub_ecc_ok(sub_ecc_ok),
        .packet_valid(packet_valid), .packet_abort(packet_abort),
        .ecc_error_count(ecc_error_count), .abort_count(abort_count)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    packet_disassembler #(.ERR_COUNT_WIDTH(3)) dut_sat (
        .clock(clock), .reset_n(reset_n), .data_island_period(data_island_period),
        .packet_data(packet_data), .header(s_header), .sub(s_sub),
        .header_ecc_ok(s_header_ecc_ok), .sub_ecc_ok(s_sub_ecc_ok),
        .packet_valid(s_packet_valid), .packet_abort(s_packet_abort),
        .ecc_error_count(s_ecc_error_count), .abort_count(s_abort_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int abort_cnt = 0;
    int overlap_cnt = 0;

    always @(negedge clock) begin
        if (packet_valid) valid_cnt++;
        if (packet_abort) abort_cnt++;
        if (packet_valid && packet_abort) overlap_cnt++;
    end

    // Reference model state: the 32 words on the wire and the packet they decode to.
    logic [8:0]   pw [32];
    logic [23:0]  m_hdr;
    logic [223:0] m_sub;
    logic         m_hok;
    logic [3:0]   m_sok;
    int           m_ecc_cnt = 0;
    int           m_abort_cnt = 0;

    function automatic logic [7:0] bch(input logic [63:0] d, input int nbits);
        logic [7:0] e = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            logic fb = e[0] ^ d[i];
            e = {1'b0, e[7:1]} ^ (fb ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    function automatic logic [223:0] rand_sub();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic make_packet(input logic [23:0] h, input logic [223:0] s);
        logic [7:0] hp;
        logic [7:0] sp [4];
        hp = bch({40'd0, h}, 24);
        for (int n = 0; n < 4; n++) sp[n] = bch({8'd0, s[56*n +: 56]}, 56);
        for (int k = 0; k < 32; k++) begin
            pw[k][0] = (k < 24) ? h[k] : hp[k-24];
            for (int n = 0; n < 4; n++) begin
                if (k < 28) begin
                    pw[k][1+n] = s[56*n + 2*k];
                    pw[k][5+n] = s[56*n + 2*k + 1];
                end else begin
                    pw[k][1+n] = sp[n][2*(k-28)];
                    pw[k][5+n] = sp[n][2*(k-28)+1];
                end
            end
        end
    endtask

    // Decode whatever is on the wire (possibly corrupted) into the expected outputs.
    task automatic model_decode();
        logic [7:0] hp;
        logic [7:0] sp [4];
        for (int k = 0; k < 32; k++) begin
            if (k < 24) m_hdr[k] = pw[k][0]; else hp[k-24] = pw[k][0];
            for (int n = 0; n < 4; n++) begin
                if (k < 28) begin
                    m_sub[56*n + 2*k]     = pw[k][1+n];
                    m_sub[56*n + 2*k + 1] = pw[k][5+n];
                end else begin
                    sp[n][2*(k-28)]   = pw[k][1+n];
                    sp[n][2*(k-28)+1] = pw[k][5+n];
                end
            end
        end
        m_hok = (bch({40'd0, m_hdr}, 24) == hp);
        for (int n = 0; n < 4; n++) m_sok[n] = (bch({8'd0, m_sub[56*n +: 56]}, 56) == sp[n]);
        if (!m_hok || m_sok != 4'hF) m_ecc_cnt++;
    endtask

    task automatic send_words(input int nw);
        for (int k = 0; k < nw; k++) begin
            @(negedge clock);
            data_island_period = 1'b1;
            packet_data = pw[k];
        end
    endtask

    task automatic go_idle(input int cycles);
        @(negedge clock);
        data_island_period = 1'b0;
        packet_data = '0;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({header, sub, header_ecc_ok, sub_ecc_ok, packet_valid, packet_abort} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got hdr=%h sub=%h hok=%b sok=%b v=%b a=%b, want all 0",
                     header, sub, header_ecc_ok, sub_ecc_ok, packet_valid, packet_abort);
        end
        n_checks++;
        if (ecc_error_count !== 16'd0 || abort_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got ecc=%0d abort=%0d, want 0 0", ecc_error_count, abort_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_null();
        int v0 = valid_cnt;
        for (int k = 0; k < 32; k++) pw[k] = '0;
        model_decode();
        send_words(32);
        @(posedge clock);
        #1;
        n_checks++;
        if (packet_valid !== 1'b1 || valid_cnt != v0) begin
            n_fail++;
            $display("FAIL null_valid_timing: got valid=%b early_pulses=%0d, want 1 and 0",
                     packet_valid, valid_cnt - v0);
        end
        n_checks++;
        if ({header, sub, header_ecc_ok, sub_ecc_ok, ecc_error_count} !== {24'd0, 224'd0, 1'b1, 4'hF, 16'd0}) begin
            n_fail++;
            $display("FAIL null_packet: got hdr=%h sub=%h hok=%b sok=%h ecc=%0d, want 0 0 1 f 0",
                     header, sub, header_ecc_ok, sub_ecc_ok, ecc_error_count);
        end
        go_idle(2);
    endtask

    task automatic test_avi(input logic corrupt);
        logic [223:0] s = rand_sub();
        make_packet(24'h0D0282, s);
        if (corrupt) begin
            pw[5][0]  = ~pw[5][0];
            pw[10][6] = ~pw[10][6];
        end
        model_decode();
        send_words(32);
        @(posedge clock);
        #1;
        n_checks++;
        if (packet_valid !== 1'b1 ||
            {header, sub, header_ecc_ok, sub_ecc_ok, ecc_error_count} !==
            {m_hdr, m_sub, m_hok, m_sok, 16'(m_ecc_cnt)}) begin
            n_fail++;
            $display("FAIL avi_packet(corrupt=%0b): got v=%b hdr=%h hok=%b sok=%b ecc=%0d sub=%h, want v=1 hdr=%h hok=%b sok=%b ecc=%0d sub=%h",
                     corrupt, packet_valid, header, header_ecc_ok, sub_ecc_ok, ecc_error_count, sub,
                     m_hdr, m_hok, m_sok, m_ecc_cnt, m_sub);
        end
        n_checks++;
        if (corrupt ? (header_ecc_ok !== 1'b0 || sub_ecc_ok !== 4'b1101)
                    : (header !== 24'h0D0282 || header_ecc_ok !== 1'b1 || sub_ecc_ok !== 4'hF || sub !== s)) begin
            n_fail++;
            $display("FAIL avi_flags(corrupt=%0b): got hdr=%h hok=%b sok=%b", corrupt, header, header_ecc_ok, sub_ecc_ok);
        end
        go_idle(2);
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        int a0 = abort_cnt;
        for (int p = 0; p < 3; p++) begin
            make_packet(24'($urandom), rand_sub());
            if (p == 1) pw[$urandom_range(0, 31)][$urandom_range(0, 8)] ^= 1'b1;
            model_decode();
            send_words(32);
            @(posedge clock);
            #1;
            n_checks++;
            if (packet_valid !== 1'b1 ||
                {header, sub, header_ecc_ok, sub_ecc_ok, ecc_error_count} !==
                {m_hdr, m_sub, m_hok, m_sok, 16'(m_ecc_cnt)}) begin
                n_fail++;
                $display("FAIL b2b_packet%0d: got v=%b hdr=%h hok=%b sok=%b ecc=%0d, want v=1 hdr=%h hok=%b sok=%b ecc=%0d",
                         p, packet_valid, header, header_ecc_ok, sub_ecc_ok, ecc_error_count,
                         m_hdr, m_hok, m_sok, m_ecc_cnt);
            end
        end
        go_idle(3);
        n_checks++;
        if (valid_cnt - v0 != 3 || abort_cnt != a0 || abort_count !== 16'(m_abort_cnt)) begin
            n_fail++;
            $display("FAIL b2b_counts: got valids=%0d aborts=%0d abort_count=%0d, want 3 0 %0d",
                     valid_cnt - v0, abort_cnt - a0, abort_count, m_abort_cnt);
        end
    endtask

    task automatic test_abort();
        logic [23:0]  prev_hdr = header;
        logic [223:0] prev_sub = sub;
        int v0 = valid_cnt;
        make_packet(24'($urandom), rand_sub());
        send_words(18);
        @(negedge clock);
        data_island_period = 1'b0;
        packet_data = '0;
        m_abort_cnt++;
        @(posedge clock);
        #1;
        n_checks++;
        if (packet_abort !== 1'b1 || packet_valid !== 1'b0 || abort_count !== 16'(m_abort_cnt)) begin
            n_fail++;
            $display("FAIL abort_strobe: got abort=%b valid=%b abort_count=%0d, want 1 0 %0d",
                     packet_abort, packet_valid, abort_count, m_abort_cnt);
        end
        n_checks++;
        if (header !== prev_hdr || sub !== prev_sub || valid_cnt != v0) begin
            n_fail++;
            $display("FAIL abort_holds: got hdr=%h valids=%0d, want hdr=%h valids=0", header, valid_cnt - v0, prev_hdr);
        end
        repeat (2) @(negedge clock);
        make_packet(24'($urandom), rand_sub());
        model_decode();
        send_words(32);
        @(posedge clock);
        #1;
        n_checks++;
        if (packet_valid !== 1'b1 || packet_abort !== 1'b0 ||
            {header, sub, header_ecc_ok, sub_ecc_ok} !== {m_hdr, m_sub, m_hok, m_sok}) begin
            n_fail++;
            $display("FAIL abort_recovery: got v=%b hdr=%h hok=%b sok=%b, want v=1 hdr=%h hok=%b sok=%b",
                     packet_valid, header, header_ecc_ok, sub_ecc_ok, m_hdr, m_hok, m_sok);
        end
        go_idle(2);
    endtask

    task automatic test_reset_mid();
        int a0;
        make_packet(24'($urandom), rand_sub());
        send_words(12);
        #2 reset_n = 1'b0;
        #1;
        m_ecc_cnt = 0;
        m_abort_cnt = 0;
        n_checks++;
        if ({header, sub, header_ecc_ok, sub_ecc_ok, packet_valid, packet_abort, ecc_error_count, abort_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got hdr=%h hok=%b sok=%b v=%b a=%b ecc=%0d ab=%0d, want all 0",
                     header, header_ecc_ok, sub_ecc_ok, packet_valid, packet_abort, ecc_error_count, abort_count);
        end
        @(negedge clock);
        data_island_period = 1'b0;
        packet_data = '0;
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        a0 = abort_cnt;
        make_packet(24'($urandom), rand_sub());
        model_decode();
        send_words(32);
        @(posedge clock);
        #1;
        n_checks++;
        if (packet_valid !== 1'b1 || abort_cnt != a0 ||
            {header, sub, header_ecc_ok, sub_ecc_ok, ecc_error_count} !== {m_hdr, m_sub, m_hok, m_sok, 16'(m_ecc_cnt)}) begin
            n_fail++;
            $display("FAIL reset_mid_next: got v=%b hdr=%h hok=%b sok=%b ecc=%0d, want v=1 hdr=%h hok=%b sok=%b ecc=%0d",
                     packet_valid, header, header_ecc_ok, sub_ecc_ok, ecc_error_count, m_hdr, m_hok, m_sok, m_ecc_cnt);
        end
        go_idle(2);
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 9; p++) begin
            make_packet(24'($urandom), rand_sub());
            pw[$urandom_range(0, 31)][$urandom_range(0, 8)] ^= 1'b1;
            model_decode();
            send_words(32);
        end
        go_idle(2);
        n_checks++;
        if (ecc_error_count !== 16'(m_ecc_cnt) || s_ecc_error_count !== 3'((m_ecc_cnt > 7) ? 7 : m_ecc_cnt)) begin
            n_fail++;
            $display("FAIL ecc_saturation: got wide=%0d narrow=%0d, want %0d %0d",
                     ecc_error_count, s_ecc_error_count, m_ecc_cnt, (m_ecc_cnt > 7) ? 7 : m_ecc_cnt);
        end
        for (int p = 0; p < 9; p++) begin
            send_words($urandom_range(1, 31));
            m_abort_cnt++;
            go_idle(1);
        end
        n_checks++;
        if (abort_count !== 16'(m_abort_cnt) || s_abort_count !== 3'((m_abort_cnt > 7) ? 7 : m_abort_cnt)) begin
            n_fail++;
            $display("FAIL abort_saturation: got wide=%0d narrow=%0d, want %0d %0d",
                     abort_count, s_abort_count, m_abort_cnt, (m_abort_cnt > 7) ? 7 : m_abort_cnt);
        end
        n_checks++;
        if (overlap_cnt != 0) begin
            n_fail++;
            $display("FAIL valid_abort_overlap: got %0d overlapping cycles, want 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_null();
        test_avi(1'b0);
        test_avi(1'b1);
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
